vid_timing_gen: RTL and testbench

Parameterised raster timing generator in the `vid_clk` domain. It produces registered `de`, `hsync` and `vsync`, active-area pixel coordinates, frame and line markers, and an optional test pattern. It sits directly upstream of the SiI9136 output register stage and replaces the inline column/line counters feeding `sii9136_de`, `sii9136_hsync`, `sii9136_vsync` and `sii9136_d`. The raster order per line and per frame is front porch, sync, back porch, then active.

---
 rtl/vid_timing_pkg.sv | 21 ++
 rtl/vid_timing_if.sv | 19 +
 rtl/vid_pattern_gen.sv | 29 ++
 rtl/vid_timing_gen.sv | 101 ++++++++++
 tb/tb_vid_timing_gen.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: 640x480@60 defaults, raster derivations and FSM encodings
package vid_timing_pkg;
    localparam int COORD_W = 12;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BACK = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BACK = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    typedef logic [COORD_W-1:0] coord_t;
    function automatic int total(int f, int s, int b, int a);
        return f + s + b + a;
    endfunction
    function automatic int blank(int f, int s, int b);
        return f + s + b;
    endfunction
endpackage

// File: rtl/vid_timing_if.sv
// vid_timing_if: raster request and timing outputs between generator and sink
interface vid_timing_if;
    import vid_timing_pkg::*;
    logic enable;
    logic de;
    logic hsync;
    logic vsync;
    coord_t pix_x;
    coord_t pix_y;
    logic frame_start;
    logic line_start;
    logic [15:0] frame_cnt;
    logic running;
    logic [35:0] pix_data;
    modport master (input enable, output de, hsync, vsync, pix_x, pix_y, frame_start,
                    line_start, frame_cnt, running, pix_data);
    modport slave (output enable, input de, hsync, vsync, pix_x, pix_y, frame_start,
                   line_start, frame_cnt, running, pix_data);
endinterface

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: registered test pattern, red/green split line moves with frame count
module vid_pattern_gen
    import vid_timing_pkg::*;
#(
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic        vid_clk,
    input  logic        vid_reset_n,
    input  logic        de,
    input  coord_t      pix_x,
    input  coord_t      pix_y,
    input  logic [8:0]  frame_cnt,
    output logic [35:0] pix_data
);
    localparam coord_t VA = coord_t'(V_ACTIVE);
    coord_t thr, xs, ys;
    logic [35:0] pix_data_d, pix_data_q;
    always_comb begin
        thr = {3'b0, frame_cnt} % VA;
        xs = pix_x << 3;
        ys = pix_y << 3;
        pix_data_d = !de ? '0 : (pix_y < thr) ? {12'hFFF, ys, xs} : {ys, 12'hFFF, xs};
    end
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) pix_data_q <= '0;
        else pix_data_q <= pix_data_d;
    end
    assign pix_data = pix_data_q;
endmodule

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing generator; VID_TIMING_PATTERN_EN adds the test pattern
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BACK = DEF_H_BACK,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BACK = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input logic          vid_clk,
    input logic          vid_reset_n,
    vid_timing_if.master vif
);
    localparam coord_t H_LAST = coord_t'(total(H_FRONT, H_SYNC, H_BACK, H_ACTIVE) - 1);
    localparam coord_t V_LAST = coord_t'(total(V_FRONT, V_SYNC, V_BACK, V_ACTIVE) - 1);
    localparam coord_t H_BL = coord_t'(blank(H_FRONT, H_SYNC, H_BACK));
    localparam coord_t V_BL = coord_t'(blank(V_FRONT, V_SYNC, V_BACK));
    localparam coord_t HS_BEG = coord_t'(H_FRONT);
    localparam coord_t HS_END = coord_t'(H_FRONT + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_FRONT);
    localparam coord_t VS_END = coord_t'(V_FRONT + V_SYNC);
    logic [0:0] state_q, state_d;
    coord_t col_q, col_d, line_q, line_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic frame_start_q, frame_start_d, line_start_q, line_start_d;
    logic run, col_wrap, frame_wrap;
    // enable only matters in IDLE or on the last pixel, so frames always complete
    always_comb begin
        run = state_q == ST_RUN;
        col_wrap = col_q == H_LAST;
        frame_wrap = col_wrap && line_q == V_LAST;
        state_d = run ? ((frame_wrap && !vif.enable) ? ST_IDLE : ST_RUN)
                      : (vif.enable ? ST_RUN : ST_IDLE);
        col_d = (run && !col_wrap) ? col_q + coord_t'(1) : '0;
        line_d = (!run || frame_wrap) ? '0 : col_wrap ? line_q + coord_t'(1) : line_q;
        frame_cnt_d = frame_cnt_q + {15'd0, run && frame_wrap};
        de_d = run && line_q >= V_BL && col_q >= H_BL;
        hsync_d = (run && col_q >= HS_BEG && col_q < HS_END) ? H_SYNC_POL : !H_SYNC_POL;
        vsync_d = (run && line_q >= VS_BEG && line_q < VS_END) ? V_SYNC_POL : !V_SYNC_POL;
        pix_x_d = de_d ? col_q - H_BL : '0;
        pix_y_d = de_d ? line_q - V_BL : '0;
        frame_start_d = run && col_q == '0 && line_q == '0;
        line_start_d = run && col_q == '0;
    end
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            state_q <= ST_IDLE;
            col_q <= '0;
            line_q <= '0;
            frame_cnt_q <= '0;
            de_q <= 1'b0;
            hsync_q <= !H_SYNC_POL;
            vsync_q <= !V_SYNC_POL;
            pix_x_q <= '0;
            pix_y_q <= '0;
            frame_start_q <= 1'b0;
            line_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            line_q <= line_d;
            frame_cnt_q <= frame_cnt_d;
            de_q <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            frame_start_q <= frame_start_d;
            line_start_q <= line_start_d;
        end
    end
    assign vif.de = de_q;
    assign vif.hsync = hsync_q;
    assign vif.vsync = vsync_q;
    assign vif.pix_x = pix_x_q;
    assign vif.pix_y = pix_y_q;
    assign vif.frame_start = frame_start_q;
    assign vif.line_start = line_start_q;
    assign vif.frame_cnt = frame_cnt_q;
    assign vif.running = state_q == ST_RUN;
`ifdef VID_TIMING_PATTERN_EN
    vid_pattern_gen #(.V_ACTIVE(V_ACTIVE)) u_pattern (
        .vid_clk(vid_clk),
        .vid_reset_n(vid_reset_n),
        .de(de_d),
        .pix_x(pix_x_d),
        .pix_y(pix_y_d),
        .frame_cnt(frame_cnt_q[8:0]),
        .pix_data(vif.pix_data)
    );
`else
    assign vif.pix_data = '0;
`endif
endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: small raster, linear-position reference model, both sync polarities
module tb_vid_timing_gen;
    localparam int HF = 3, HS = 4, HB = 2, HA = 12, VF = 2, VS = 2, VB = 1, VA = 10;
    localparam int HT = HF + HS + HB + HA, VT = VF + VS + VB + VA, FR = HT * VT;
    localparam int HBL = HF + HS + HB, VBL = VF + VS + VB;

    logic clk = 1'b0;
    logic rst_n, enable;
    always #5 clk = ~clk;

    vid_timing_if vif_p ();
    vid_timing_if vif_n ();
    assign vif_p.enable = enable;
    assign vif_n.enable = enable;

    vid_timing_gen #(.H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
                     .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
                     .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1))
        dut_p (.vid_clk(clk), .vid_reset_n(rst_n), .vif(vif_p.master));
    vid_timing_gen #(.H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
                     .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
                     .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0))
        dut_n (.vid_clk(clk), .vid_reset_n(rst_n), .vif(vif_n.master));

    int checks = 0, fails = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef VID_TIMING_PATTERN_EN
    function automatic logic [35:0] pat(input bit de, input int x, input int y, input int f);
        int thr;
        logic [11:0] xs, ys;
        thr = (f % 512) % VA;
        xs = 12'(x * 8);
        ys = 12'(y * 8);
        if (!de) return 36'd0;
        return (y < thr) ? {12'hFFF, ys, xs} : {ys, 12'hFFF, xs};
    endfunction
`endif

    // Reference: one linear position per frame; column/line come from div/mod.
    bit m_run;
    int m_pos, m_frames, mc, ml;
    logic e_de, e_hs, e_vs, e_fs, e_ls, e_run;
    logic [11:0] e_x, e_y;
    logic [15:0] e_fc;
    logic [35:0] e_pd;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_frames = 0;
            e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_ls = 0; e_run = 0;
            e_x = 0; e_y = 0; e_fc = 0; e_pd = 0;
        end else begin
            mc = m_pos % HT;
            ml = m_pos / HT;
            e_de = m_run && ml >= VBL && mc >= HBL;
            e_x = e_de ? 12'(mc - HBL) : 12'd0;
            e_y = e_de ? 12'(ml - VBL) : 12'd0;
            e_hs = m_run && mc >= HF && mc < HF + HS;
            e_vs = m_run && ml >= VF && ml < VF + VS;
            e_fs = m_run && m_pos == 0;
            e_ls = m_run && mc == 0;
`ifdef VID_TIMING_PATTERN_EN
            e_pd = pat(e_de, int'(e_x), int'(e_y), m_frames);
`else
            e_pd = 36'd0;
`endif
            if (!m_run) m_run = enable;
            else if (m_pos == FR - 1) begin
                m_pos = 0;
                m_frames++;
                m_run = enable;
            end else m_pos++;
            e_run = m_run;
            e_fc = 16'(m_frames);
        end
    end

    int cyc = 0, fs_last = 0, fs_period = 0, ls_last = 0, ls_period = 0;
    int de_acc = 0, de_frame = 0, max_x = 0, max_y = 0;
    int hs_off = 0, hs_cnt = 0, hs_width = 0, vs_off = 0, vs_cnt = 0, vs_width = 0;
    bit hs_prev = 0, vs_prev = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_on) begin
            chk("de", 36'(vif_p.de), 36'(e_de));
            chk("hsync", 36'(vif_p.hsync), 36'(e_hs));
            chk("vsync", 36'(vif_p.vsync), 36'(e_vs));
            chk("pix_x", 36'(vif_p.pix_x), 36'(e_x));
            chk("pix_y", 36'(vif_p.pix_y), 36'(e_y));
            chk("frame_start", 36'(vif_p.frame_start), 36'(e_fs));
            chk("line_start", 36'(vif_p.line_start), 36'(e_ls));
            chk("frame_cnt", 36'(vif_p.frame_cnt), 36'(e_fc));
            chk("running", 36'(vif_p.running), 36'(e_run));
            chk("pix_data", vif_p.pix_data, e_pd);
            chk("hsync_lowpol", 36'(vif_n.hsync), 36'(!e_hs));
            chk("vsync_lowpol", 36'(vif_n.vsync), 36'(!e_vs));
            chk("de_lowpol", 36'(vif_n.de), 36'(e_de));
        end
        if (vif_p.frame_start) begin
            if (fs_last > 0) fs_period = cyc - fs_last;
            fs_last = cyc;
            de_frame = de_acc;
            de_acc = 0;
        end
        if (vif_p.line_start) begin
            if (ls_last > 0) ls_period = cyc - ls_last;
            ls_last = cyc;
        end
        if (vif_p.de) begin
            de_acc++;
            if (int'(vif_p.pix_x) > max_x) max_x = int'(vif_p.pix_x);
            if (int'(vif_p.pix_y) > max_y) max_y = int'(vif_p.pix_y);
        end
        if (vif_p.hsync && !hs_prev) begin hs_off = cyc - ls_last; hs_cnt = 0; end
        if (vif_p.hsync) hs_cnt++; else if (hs_prev) hs_width = hs_cnt;
        hs_prev = vif_p.hsync;
        if (vif_p.vsync && !vs_prev) begin vs_off = cyc - fs_last; vs_cnt = 0; end
        if (vif_p.vsync) vs_cnt++; else if (vs_prev) vs_width = vs_cnt;
        vs_prev = vif_p.vsync;
    end

    int n, fc0;
    initial begin
        rst_n = 0;
        enable = 0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_de", 36'(vif_p.de), 36'd0);
        chk("rst_hsync_hi", 36'(vif_p.hsync), 36'd0);
        chk("rst_hsync_lo", 36'(vif_n.hsync), 36'd1);
        chk("rst_vsync_lo", 36'(vif_n.vsync), 36'd1);
        chk("rst_frame_cnt", 36'(vif_p.frame_cnt), 36'd0);
        chk("rst_running", 36'(vif_p.running), 36'd0);
        chk("rst_pix_data", vif_p.pix_data, 36'd0);
        rst_n = 1;
        repeat (5) @(negedge clk);
        enable = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!vif_p.frame_start && n < 10);
        chk("fs_latency", 36'(n), 36'd2);
        repeat (3 * FR) @(negedge clk);
        chk("fs_period", 36'(fs_period), 36'd315);
        chk("ls_period", 36'(ls_period), 36'd21);
        chk("de_per_frame", 36'(de_frame), 36'd120);
        chk("max_pix_x", 36'(max_x), 36'd11);
        chk("max_pix_y", 36'(max_y), 36'd9);
        chk("hs_width", 36'(hs_width), 36'd4);
        chk("hs_offset", 36'(hs_off), 36'd3);
        chk("vs_width", 36'(vs_width), 36'd42);
        chk("vs_offset", 36'(vs_off), 36'd42);
        n = 0;
        while (!(vif_p.de && vif_p.pix_y == 12'd4) && n < 2 * FR) begin @(negedge clk); n++; end
        chk("wait_line4", 36'(n < 2 * FR), 36'd1);
        fc0 = int'(vif_p.frame_cnt);
        enable = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (vif_p.running && n < 2 * FR);
        chk("drop_cycles", 36'(n), 36'd116);
        chk("drop_frame_cnt", 36'(vif_p.frame_cnt), 36'(fc0 + 1));
        repeat (20) @(negedge clk);
        chk("idle_de", 36'(vif_p.de), 36'd0);
        chk("idle_hsync_lo", 36'(vif_n.hsync), 36'd1);
        chk("idle_running", 36'(vif_p.running), 36'd0);
        repeat (4000) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) enable = ~enable;
        end
        enable = 1;
        n = 0;
        while (!(vif_p.de && vif_p.pix_y == 12'd5) && n < 3 * FR) begin @(negedge clk); n++; end
        chk("wait_line5", 36'(n < 3 * FR), 36'd1);
        #2 rst_n = 0;
        #1;
        chk("arst_de", 36'(vif_p.de), 36'd0);
        chk("arst_pix_y", 36'(vif_p.pix_y), 36'd0);
        chk("arst_hsync_hi", 36'(vif_p.hsync), 36'd0);
        chk("arst_vsync_lo", 36'(vif_n.vsync), 36'd1);
        chk("arst_running", 36'(vif_p.running), 36'd0);
        chk("arst_frame_cnt", 36'(vif_p.frame_cnt), 36'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!vif_p.frame_start && n < 10);
        chk("arst_fs_latency", 36'(n), 36'd2);
`ifdef VID_TIMING_PATTERN_EN
        n = 0;
        while (!(vif_p.frame_cnt == 16'd5 && vif_p.de && vif_p.pix_x == 12'd10 && vif_p.pix_y == 12'd2)
               && n < 8 * FR) begin @(negedge clk); n++; end
        chk("pat_x10_y2", vif_p.pix_data, {12'hFFF, 12'd16, 12'd80});
        n = 0;
        while (!(vif_p.frame_cnt == 16'd5 && vif_p.de && vif_p.pix_y == 12'd7) && n < 2 * FR) begin
            @(negedge clk); n++;
        end
        chk("pat_y7_r", 36'(vif_p.pix_data[35:24]), 36'd56);
        chk("pat_y7_g", 36'(vif_p.pix_data[23:12]), 36'hFFF);
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
